store4_latch_array: RTL and testbench



---
 rtl/store4_pkg.sv | 18 +
 rtl/store4_cell.sv | 23 ++
 rtl/store4_latch_array.sv | 49 ++++
 tb/tb_store4_latch_array.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/store4_pkg.sv
// Shared types and index constants for the 2x2 storage array.
package store4_pkg;

  localparam int IDX_R0C0 = 0;
  localparam int IDX_R0C1 = 1;
  localparam int IDX_R1C0 = 2;
  localparam int IDX_R1C1 = 3;

  localparam int NUM_ROWS = 2;
  localparam int NUM_COLS = 2;

  typedef logic [0:3] store4_word_t;

  function automatic int cell_idx(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction

endpackage

// File: rtl/store4_cell.sv
// Single storage bit: enabled D flop with synchronous reset value.
module store4_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/store4_latch_array.sv
// 2x2 clocked store: rows fed by dat0/dat1, columns written by cap0/cap1.
// Optional even-parity output when STORE4_PARITY_EN is defined.
module store4_latch_array
  import store4_pkg::*;
#(
  parameter store4_word_t RESET_VAL = 4'b0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dat0,
  input  logic         dat1,
  input  logic         cap0,
  input  logic         cap1,
  output store4_word_t out
`ifdef STORE4_PARITY_EN
  ,
  output logic         parity
`endif
);

  logic [NUM_ROWS-1:0] w_dat;
  logic [NUM_COLS-1:0] w_cap;
  store4_word_t        w_q;

  assign w_dat = {dat1, dat0};
  assign w_cap = {cap1, cap0};

  // Cell (row, col) takes its row's data and its column's strobe.
  for (genvar row = 0; row < NUM_ROWS; row++) begin : g_row
    for (genvar col = 0; col < NUM_COLS; col++) begin : g_col
      localparam int IDX = row * NUM_COLS + col;
      store4_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .rst_val(RESET_VAL[IDX]),
        .en     (w_cap[col]),
        .d      (w_dat[row]),
        .q      (w_q[IDX])
      );
    end
  end

  assign out = w_q;

`ifdef STORE4_PARITY_EN
  assign parity = ^w_q;
`endif

endmodule

// File: tb/tb_store4_latch_array.sv
// Directed self-checking bench for store4_latch_array.
module tb_store4_latch_array;

  logic       clk;
  logic       rst;
  logic       dat0;
  logic       dat1;
  logic       cap0;
  logic       cap1;
  logic [0:3] out;
`ifdef STORE4_PARITY_EN
  logic       parity;
`endif

  int total;
  int bad;

  store4_latch_array #(.RESET_VAL(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .dat0(dat0),
    .dat1(dat1),
    .cap0(cap0),
    .cap1(cap1),
    .out (out)
`ifdef STORE4_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic c0, input logic c1);
    cap0 = c0;
    cap1 = c1;
    edge1();
    cap0 = 1'b0;
    cap1 = 1'b0;
  endtask

  task automatic chk_par(input string tag, input logic [3:0] exp);
`ifdef STORE4_PARITY_EN
    chk(tag, {3'b000, parity}, {3'b000, ^exp});
`else
    chk(tag, 4'b0000, 4'b0000 & exp);
`endif
  endtask

  task automatic load(input logic [3:0] p, input string tag);
    dat0 = p[3];
    dat1 = p[1];
    pulse(1'b1, 1'b0);
    dat0 = p[2];
    dat1 = p[0];
    pulse(1'b0, 1'b1);
    chk(tag, out, p);
  endtask

  logic [3:0] pats [4];

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    dat0 = 1'b0;
    dat1 = 1'b0;
    cap0 = 1'b0;
    cap1 = 1'b0;
    edge1();
    edge1();
    rst = 1'b0;
    chk("reset", out, 4'b0000);
`ifdef STORE4_PARITY_EN
    chk("reset_par", {3'b000, parity}, 4'b0000);
`endif

    dat0 = 1'b1; pulse(1'b1, 1'b0);
    chk("r0c0_set", out, 4'b1000);
    dat0 = 1'b0; pulse(1'b1, 1'b0);
    chk("r0c0_clr", out, 4'b0000);
    dat0 = 1'b1; pulse(1'b0, 1'b1);
    chk("r0c1_set", out, 4'b0100);
    dat0 = 1'b0; pulse(1'b0, 1'b1);
    chk("r0c1_clr", out, 4'b0000);
    dat1 = 1'b1; pulse(1'b1, 1'b0);
    chk("r1c0_set", out, 4'b0010);
    dat1 = 1'b0; pulse(1'b1, 1'b0);
    chk("r1c0_clr", out, 4'b0000);
    dat1 = 1'b1; pulse(1'b0, 1'b1);
    chk("r1c1_set", out, 4'b0001);
    dat1 = 1'b0; pulse(1'b0, 1'b1);
    chk("r1c1_clr", out, 4'b0000);

    // Store a nonzero value so hold is meaningful.
    load(4'b1001, "pre_hold");
    for (int i = 0; i < 4; i++) begin
      dat0 = ~dat0;
      dat1 = ~dat1;
      edge1();
      chk("hold", out, 4'b1001);
    end

    pats[0] = 4'b1010;
    pats[1] = 4'b0101;
    pats[2] = 4'b1111;
    pats[3] = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load(pats[i], "pattern");
      chk_par("pattern_par", pats[i]);
    end

    dat0 = 1'b1;
    dat1 = 1'b0;
    pulse(1'b1, 1'b1);
    chk("simul", out, 4'b1100);
    chk_par("simul_par", 4'b1100);

    // Strobe held for several cycles: last sampled data wins.
    cap0 = 1'b1;
    dat0 = 1'b0; dat1 = 1'b1;
    edge1();
    chk("held_1", out, 4'b0110);
    dat0 = 1'b1; dat1 = 1'b0;
    edge1();
    chk("held_2", out, 4'b1100);
    dat0 = 1'b0; dat1 = 1'b0;
    edge1();
    cap0 = 1'b0;
    chk("held_3", out, 4'b0100);

    rst = 1'b1;
    cap0 = 1'b1;
    dat0 = 1'b1;
    edge1();
    rst = 1'b0;
    cap0 = 1'b0;
    chk("rst_mid", out, 4'b0000);
    chk_par("rst_mid_par", 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
